movie_theater_area_engine: RTL and testbench

MOVIE_THEATER_AREA_ENGINE -- requirements
Module: movie_theater_area_engine

---
 rtl/movie_theater_area_engine_if.sv | 15 +
 rtl/movie_theater_area_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_movie_theater_area_engine.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/movie_theater_area_engine_if.sv
// Point-load handshake between a point source (master) and the area engine (slave).
//   in_valid : point offered by the master
//   in_ready : engine can accept a point this cycle
//   in_x/in_y: unsigned point coordinates
interface movie_theater_area_engine_if #(
  parameter int unsigned COORD_WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [COORD_WIDTH-1:0] in_x;
  logic [COORD_WIDTH-1:0] in_y;

  modport master (output in_valid, output in_x, output in_y, input in_ready);
  modport slave  (input in_valid, input in_x, input in_y, output in_ready);
endinterface

// File: rtl/movie_theater_area_engine.sv
// Maximum axis-aligned rectangle area over all pairs of loaded points.
// Points are loaded through the pt handshake, then a start launches a pairwise
// scan (one pair per cycle) through a 3-stage read/diff, multiply, compare pipe.
//   clk, rst_n       : clock, asynchronous active-low reset
//   pt               : point load handshake (slave side)
//   clear            : empty the point memory (ignored while busy)
//   start            : begin a scan of the loaded points (ignored while busy)
//   busy             : scan in progress
//   done             : result valid, held until next start or clear
//   result           : maximum area found
//   best_i, best_j   : indices of the winning pair (best_i < best_j)
//   num_points       : number of points currently loaded
module movie_theater_area_engine #(
  parameter int unsigned MAX_POINTS  = 512,
  parameter int unsigned COORD_WIDTH = 32,
  parameter int unsigned INCLUSIVE   = 1,
  localparam int unsigned IDX_WIDTH  = $clog2(MAX_POINTS + 1),
  localparam int unsigned AREA_WIDTH = 2 * COORD_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  movie_theater_area_engine_if.slave pt,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [AREA_WIDTH-1:0]      result,
  output logic [IDX_WIDTH-1:0]       best_i,
  output logic [IDX_WIDTH-1:0]       best_j,
  output logic [IDX_WIDTH-1:0]       num_points
);
  localparam int unsigned ADDR_WIDTH = $clog2(MAX_POINTS);
  localparam int unsigned EXT_WIDTH  = COORD_WIDTH + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [IDX_WIDTH-1:0] IDX_MAX = IDX_WIDTH'(MAX_POINTS);
  localparam logic [EXT_WIDTH-1:0] EXT_INC = EXT_WIDTH'(INCLUSIVE != 0);

  logic [1:0]             state_q, state_d;
  logic [IDX_WIDTH-1:0]   num_q, num_d, n_scan_q, n_scan_d;
  logic [IDX_WIDTH-1:0]   i_q, i_d, j_q, j_d;
  logic                   iss_v_q, iss_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [IDX_WIDTH-1:0]   iss_i_q, iss_i_d, iss_j_q, iss_j_d;
  logic [IDX_WIDTH-1:0]   s1_i_q, s1_i_d, s1_j_q, s1_j_d;
  logic [IDX_WIDTH-1:0]   s2_i_q, s2_i_d, s2_j_q, s2_j_d;
  logic [COORD_WIDTH-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic [AREA_WIDTH-1:0]  s2_area_q, s2_area_d;
  logic [AREA_WIDTH-1:0]  max_q, max_d;
  logic [IDX_WIDTH-1:0]   max_i_q, max_i_d, max_j_q, max_j_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [AREA_WIDTH-1:0]  result_q, result_d;
  logic [IDX_WIDTH-1:0]   best_i_q, best_i_d, best_j_q, best_j_d;

  logic [COORD_WIDTH-1:0] mem_x_q [MAX_POINTS];
  logic [COORD_WIDTH-1:0] mem_y_q [MAX_POINTS];
  logic [COORD_WIDTH-1:0] rd_xi, rd_xj, rd_yi, rd_yj;
  logic [EXT_WIDTH-1:0]   ext_dx, ext_dy;
  logic                   ready_c, accept_c, wr_en_c;

  assign ready_c       = ((state_q == S_IDLE) || (state_q == S_DONE)) && (num_q < IDX_MAX);
  assign accept_c      = pt.in_valid && ready_c;
  assign pt.in_ready   = ready_c;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign best_i        = best_i_q;
  assign best_j        = best_j_q;
  assign num_points    = num_q;

  // Control FSM, pair issue and running-max update
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    n_scan_d = n_scan_q;
    i_d      = i_q;
    j_d      = j_q;
    iss_v_d  = 1'b0;
    iss_i_d  = iss_i_q;
    iss_j_d  = iss_j_q;
    max_d    = max_q;
    max_i_d  = max_i_q;
    max_j_d  = max_j_q;
    done_d   = done_q;
    result_d = result_q;
    best_i_d = best_i_q;
    best_j_d = best_j_q;
    wr_en_c  = 1'b0;

    // strictly-greater update keeps the earliest pair on ties
    if (s2_v_q && (s2_area_q > max_q)) begin
      max_d   = s2_area_q;
      max_i_d = s2_i_q;
      max_j_d = s2_j_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear) begin
          num_d   = '0;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (accept_c) begin
            wr_en_c = 1'b1;
            num_d   = num_q + IDX_WIDTH'(1);
          end
          if (start) begin
            state_d  = S_RUN;
            done_d   = 1'b0;
            n_scan_d = num_d;
            i_d      = '0;
            j_d      = IDX_WIDTH'(1);
            max_d    = '0;
            max_i_d  = '0;
            max_j_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (n_scan_q < IDX_WIDTH'(2)) begin
          state_d = S_DRAIN;
        end else begin
          iss_v_d = 1'b1;
          iss_i_d = i_q;
          iss_j_d = j_q;
          if (j_q == n_scan_q - IDX_WIDTH'(1)) begin
            if (i_q == n_scan_q - IDX_WIDTH'(2)) begin
              state_d = S_DRAIN;
            end else begin
              i_d = i_q + IDX_WIDTH'(1);
              j_d = i_q + IDX_WIDTH'(2);
            end
          end else begin
            j_d = j_q + IDX_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!iss_v_q && !s1_v_q && !s2_v_q) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = max_q;
          best_i_d = max_i_q;
          best_j_d = max_j_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // busy drops on the same edge done rises
    busy_d = (state_q == S_RUN) || ((state_q == S_DRAIN) && (state_d == S_DRAIN));
  end

  // Datapath: read + absolute differences, then full-width product
  always_comb begin
    rd_xi     = mem_x_q[ADDR_WIDTH'(iss_i_q)];
    rd_xj     = mem_x_q[ADDR_WIDTH'(iss_j_q)];
    rd_yi     = mem_y_q[ADDR_WIDTH'(iss_i_q)];
    rd_yj     = mem_y_q[ADDR_WIDTH'(iss_j_q)];
    s1_v_d    = iss_v_q;
    s1_i_d    = iss_i_q;
    s1_j_d    = iss_j_q;
    s1_dx_d   = (rd_xi > rd_xj) ? rd_xi - rd_xj : rd_xj - rd_xi;
    s1_dy_d   = (rd_yi > rd_yj) ? rd_yi - rd_yj : rd_yj - rd_yi;
    ext_dx    = EXT_WIDTH'(s1_dx_q) + EXT_INC;
    ext_dy    = EXT_WIDTH'(s1_dy_q) + EXT_INC;
    s2_v_d    = s1_v_q;
    s2_i_d    = s1_i_q;
    s2_j_d    = s1_j_q;
    s2_area_d = AREA_WIDTH'(ext_dx) * AREA_WIDTH'(ext_dy);
  end

  // Point memory (no reset; only read after being written)
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_x_q[ADDR_WIDTH'(num_q)] <= pt.in_x;
      mem_y_q[ADDR_WIDTH'(num_q)] <= pt.in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      n_scan_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      iss_v_q   <= 1'b0;
      iss_i_q   <= '0;
      iss_j_q   <= '0;
      s1_v_q    <= 1'b0;
      s1_i_q    <= '0;
      s1_j_q    <= '0;
      s1_dx_q   <= '0;
      s1_dy_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_i_q    <= '0;
      s2_j_q    <= '0;
      s2_area_q <= '0;
      max_q     <= '0;
      max_i_q   <= '0;
      max_j_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      best_i_q  <= '0;
      best_j_q  <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      n_scan_q  <= n_scan_d;
      i_q       <= i_d;
      j_q       <= j_d;
      iss_v_q   <= iss_v_d;
      iss_i_q   <= iss_i_d;
      iss_j_q   <= iss_j_d;
      s1_v_q    <= s1_v_d;
      s1_i_q    <= s1_i_d;
      s1_j_q    <= s1_j_d;
      s1_dx_q   <= s1_dx_d;
      s1_dy_q   <= s1_dy_d;
      s2_v_q    <= s2_v_d;
      s2_i_q    <= s2_i_d;
      s2_j_q    <= s2_j_d;
      s2_area_q <= s2_area_d;
      max_q     <= max_d;
      max_i_q   <= max_i_d;
      max_j_q   <= max_j_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      best_i_q  <= best_i_d;
      best_j_q  <= best_j_d;
    end
  end
endmodule

// File: tb/tb_movie_theater_area_engine.sv
// Bench for movie_theater_area_engine: three configurations share one stimulus
//   d0: MAX_POINTS=512, COORD_WIDTH=32, INCLUSIVE=1
//   d1: MAX_POINTS=4,   COORD_WIDTH=8,  INCLUSIVE=1
//   d2: MAX_POINTS=8,   COORD_WIDTH=32, INCLUSIVE=0
module tb_movie_theater_area_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clear = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [31:0] in_x = '0, in_y = '0;

  movie_theater_area_engine_if #(.COORD_WIDTH(32)) if_a ();
  movie_theater_area_engine_if #(.COORD_WIDTH(8))  if_b ();
  movie_theater_area_engine_if #(.COORD_WIDTH(32)) if_c ();
  assign if_a.in_valid = in_valid;
  assign if_a.in_x     = in_x;
  assign if_a.in_y     = in_y;
  assign if_b.in_valid = in_valid;
  assign if_b.in_x     = in_x[7:0];
  assign if_b.in_y     = in_y[7:0];
  assign if_c.in_valid = in_valid;
  assign if_c.in_x     = in_x;
  assign if_c.in_y     = in_y;

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [64:0] res_a, res_c;
  logic [16:0] res_b;
  logic [9:0]  bi_a, bj_a, num_a;
  logic [2:0]  bi_b, bj_b, num_b;
  logic [3:0]  bi_c, bj_c, num_c;

  movie_theater_area_engine #(.MAX_POINTS(512), .COORD_WIDTH(32), .INCLUSIVE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pt(if_a), .clear(clear), .start(start), .busy(busy_a),
    .done(done_a), .result(res_a), .best_i(bi_a), .best_j(bj_a), .num_points(num_a));
  movie_theater_area_engine #(.MAX_POINTS(4), .COORD_WIDTH(8), .INCLUSIVE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pt(if_b), .clear(clear), .start(start), .busy(busy_b),
    .done(done_b), .result(res_b), .best_i(bi_b), .best_j(bj_b), .num_points(num_b));
  movie_theater_area_engine #(.MAX_POINTS(8), .COORD_WIDTH(32), .INCLUSIVE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .pt(if_c), .clear(clear), .start(start), .busy(busy_c),
    .done(done_c), .result(res_c), .best_i(bi_c), .best_j(bj_c), .num_points(num_c));

  int cap  [3] = '{512, 4, 8};
  int cw   [3] = '{32, 8, 32};
  int incl [3] = '{1, 1, 0};

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] px [16];
  logic [31:0] py [16];
  int          pn;

  logic        cur_done [3], cur_busy [3], cur_ready [3];
  logic [64:0] cur_res [3];
  int          cur_bi [3], cur_bj [3], cur_num [3];

  typedef struct {
    int          n;
    logic [31:0] x [6];
    logic [31:0] y [6];
    logic [64:0] res [3];
    int          bi [3];
    int          bj [3];
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    cur_done[0] = done_a;  cur_busy[0] = busy_a;  cur_ready[0] = if_a.in_ready;
    cur_done[1] = done_b;  cur_busy[1] = busy_b;  cur_ready[1] = if_b.in_ready;
    cur_done[2] = done_c;  cur_busy[2] = busy_c;  cur_ready[2] = if_c.in_ready;
    cur_res[0] = res_a;    cur_res[1] = 65'(res_b); cur_res[2] = res_c;
    cur_bi[0] = int'(bi_a); cur_bj[0] = int'(bj_a); cur_num[0] = int'(num_a);
    cur_bi[1] = int'(bi_b); cur_bj[1] = int'(bj_b); cur_num[1] = int'(num_b);
    cur_bi[2] = int'(bi_c); cur_bj[2] = int'(bj_c); cur_num[2] = int'(num_c);
  endtask

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int loaded(input int d);
    return (pn < cap[d]) ? pn : cap[d];
  endfunction

  // Reference: brute force over all pairs in scan order, strictly-greater wins
  task automatic model(input int d, output logic [64:0] area, output int bi, output int bj);
    logic [64:0] m, xi, xj, yi, yj, dx, dy, a;
    int n;
    n = loaded(d);
    m = (65'd1 << cw[d]) - 65'd1;
    area = '0; bi = 0; bj = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        xi = 65'(px[i]) & m; xj = 65'(px[j]) & m;
        yi = 65'(py[i]) & m; yj = 65'(py[j]) & m;
        dx = (xi > xj) ? xi - xj : xj - xi;
        dy = (yi > yj) ? yi - yj : yj - yi;
        a  = (dx + 65'(incl[d])) * (dy + 65'(incl[d]));
        if (a > area) begin area = a; bi = i; bj = j; end
      end
    end
  endtask

  task automatic load(input int upto);
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < upto; k++) begin
      in_valid = 1'b1; in_x = px[k]; in_y = py[k];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Optional reload, start, check done timing and busy window, check hold
  task automatic run_scan(input bit reload, input bit start_last, input string tag);
    int exp_done [3], seen [3], n;
    bit bok [3], all;
    if (reload) begin
      load(start_last ? pn - 1 : pn);
      if (!start_last) begin
        sample();
        for (int d = 0; d < 3; d++)
          check($sformatf("%s d%0d in_ready", tag, d), 65'(cur_ready[d]), 65'(loaded(d) < cap[d]));
      end
    end
    if (start_last) begin
      in_valid = 1'b1; in_x = px[pn-1]; in_y = py[pn-1];
    end
    start = 1'b1; tick(); start = 1'b0; in_valid = 1'b0;
    sample();
    for (int d = 0; d < 3; d++) begin
      n = loaded(d);
      exp_done[d] = (n < 2) ? 2 : n * (n - 1) / 2 + 4;
      seen[d] = cur_done[d] ? 0 : -1;
      bok[d]  = !cur_busy[d];
    end
    all = 1'b0;
    for (int e = 1; e <= 300 && !all; e++) begin
      tick(); sample();
      all = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (seen[d] < 0) begin
          if (cur_done[d]) begin
            seen[d] = e;
            if (cur_busy[d]) bok[d] = 1'b0;
          end else if (!cur_busy[d]) bok[d] = 1'b0;
        end
        if (seen[d] < 0) all = 1'b0;
      end
    end
    tick(); sample();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s d%0d done_edge", tag, d), 65'(seen[d]), 65'(exp_done[d]));
      check($sformatf("%s d%0d busy_window", tag, d), 65'(bok[d]), 65'd1);
      check($sformatf("%s d%0d done_held", tag, d), 65'(cur_done[d]), 65'd1);
    end
  endtask

  task automatic check_out(input string tag, input int d, input logic [64:0] er,
                           input int ebi, input int ebj);
    check($sformatf("%s d%0d result", tag, d), cur_res[d], er);
    check($sformatf("%s d%0d best_i", tag, d), 65'(cur_bi[d]), 65'(ebi));
    check($sformatf("%s d%0d best_j", tag, d), 65'(cur_bj[d]), 65'(ebj));
    check($sformatf("%s d%0d num_points", tag, d), 65'(cur_num[d]), 65'(loaded(d)));
  endtask

  task automatic check_model(input string tag);
    logic [64:0] er;
    int ebi, ebj;
    for (int d = 0; d < 3; d++) begin
      model(d, er, ebi, ebj);
      check_out(tag, d, er, ebi, ebj);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0].n = 4; tbl[0].x = '{2, 11, 7, 2, 0, 0};   tbl[0].y = '{5, 1, 3, 3, 0, 0};
    tbl[0].res = '{50, 50, 36};       tbl[0].bi = '{0, 0, 0}; tbl[0].bj = '{1, 1, 1};
    tbl[1].n = 4; tbl[1].x = '{0, 2, 2, 0, 0, 0};    tbl[1].y = '{0, 2, 0, 2, 0, 0};
    tbl[1].res = '{9, 9, 4};          tbl[1].bi = '{0, 0, 0}; tbl[1].bj = '{1, 1, 1};
    tbl[2].n = 2; tbl[2].x = '{0, 255, 0, 0, 0, 0};  tbl[2].y = '{0, 255, 0, 0, 0, 0};
    tbl[2].res = '{65536, 65536, 65025}; tbl[2].bi = '{0, 0, 0}; tbl[2].bj = '{1, 1, 1};
    tbl[3].n = 0; tbl[3].x = '{0, 0, 0, 0, 0, 0};    tbl[3].y = '{0, 0, 0, 0, 0, 0};
    tbl[3].res = '{0, 0, 0};          tbl[3].bi = '{0, 0, 0}; tbl[3].bj = '{0, 0, 0};
    tbl[4].n = 1; tbl[4].x = '{7, 0, 0, 0, 0, 0};    tbl[4].y = '{9, 0, 0, 0, 0, 0};
    tbl[4].res = '{0, 0, 0};          tbl[4].bi = '{0, 0, 0}; tbl[4].bj = '{0, 0, 0};
    tbl[5].n = 5; tbl[5].x = '{1, 3, 0, 2, 200, 0};  tbl[5].y = '{1, 4, 0, 2, 200, 0};
    tbl[5].res = '{40401, 20, 40000}; tbl[5].bi = '{2, 1, 2}; tbl[5].bj = '{4, 2, 4};

    // reset state
    repeat (2) tick();
    sample();
    pn = 0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset d%0d busy", d), 65'(cur_busy[d]), 65'd0);
      check($sformatf("reset d%0d done", d), 65'(cur_done[d]), 65'd0);
      check_out("reset", d, 65'd0, 0, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); sample();
    for (int d = 0; d < 3; d++)
      check($sformatf("post_reset d%0d in_ready", d), 65'(cur_ready[d]), 65'd1);

    // table-driven vectors
    for (int k = 0; k < 6; k++) begin
      pn = tbl[k].n;
      for (int p = 0; p < 6; p++) begin px[p] = tbl[k].x[p]; py[p] = tbl[k].y[p]; end
      run_scan(1'b1, 1'b0, $sformatf("vec%0d", k));
      for (int d = 0; d < 3; d++)
        check_out($sformatf("vec%0d", k), d, tbl[k].res[d], tbl[k].bi[d], tbl[k].bj[d]);
    end

    // point accepted on the same edge as start joins the scan
    pn = 3;
    px[0] = 1; py[0] = 2; px[1] = 9; py[1] = 8; px[2] = 4; py[2] = 20;
    run_scan(1'b1, 1'b1, "start_with_point");
    check_model("start_with_point");

    // rescan of retained memory
    run_scan(1'b0, 1'b0, "rescan");
    check_model("rescan");

    // clear wins over an offered point; done drops
    clear = 1'b1; in_valid = 1'b1; in_x = 32'd5; in_y = 32'd6;
    tick(); clear = 1'b0; in_valid = 1'b0;
    sample();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("clear_valid d%0d num", d), 65'(cur_num[d]), 65'd0);
      check($sformatf("clear_valid d%0d done", d), 65'(cur_done[d]), 65'd0);
    end

    // start with clear in IDLE: clear wins, no scan
    pn = 2; px[0] = 3; py[0] = 3; px[1] = 8; py[1] = 1;
    load(2);
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    repeat (3) tick();
    sample();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("start_clear d%0d busy", d), 65'(cur_busy[d]), 65'd0);
      check($sformatf("start_clear d%0d done", d), 65'(cur_done[d]), 65'd0);
      check($sformatf("start_clear d%0d num", d), 65'(cur_num[d]), 65'd0);
    end

    // randomized scans against the reference model
    for (int r = 0; r < 14; r++) begin
      pn = int'($urandom_range(0, 8));
      for (int p = 0; p < pn; p++) begin
        if (r % 2 == 0) begin
          px[p] = 32'($urandom_range(0, 15)); py[p] = 32'($urandom_range(0, 15));
        end else begin
          px[p] = $urandom(); py[p] = $urandom();
        end
      end
      run_scan(1'b1, (pn > 0) && ($urandom_range(0, 1) == 1), $sformatf("rand%0d", r));
      check_model($sformatf("rand%0d", r));
    end

    // asynchronous reset in the middle of a scan
    pn = 5;
    for (int p = 0; p < 5; p++) begin px[p] = 32'(p * 3); py[p] = 32'(p * 5 + 1); end
    load(5);
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    sample();
    check("pre_reset d0 busy", 65'(cur_busy[0]), 65'd1);
    #2 rst_n = 1'b0;
    #1 sample();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("async_reset d%0d busy", d), 65'(cur_busy[d]), 65'd0);
      check($sformatf("async_reset d%0d done", d), 65'(cur_done[d]), 65'd0);
      check($sformatf("async_reset d%0d num", d), 65'(cur_num[d]), 65'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); sample();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("after_abort d%0d in_ready", d), 65'(cur_ready[d]), 65'd1);
      check($sformatf("after_abort d%0d result", d), cur_res[d], 65'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
